// File: rtl/game_frame_controller.sv
// Frame sequencer: stalls the core between frames, snapshots the newest PS/2 key,
// and commits shadow player/enemy words atomically when the core writes DONE.
module game_frame_controller #(
    parameter int unsigned FRAME_CYCLES = 1000,
    parameter logic [31:0] IO_BASE      = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        ps2_valid,
    input  logic [7:0]  ps2_code,
    output logic        cpu_stall,
    output logic [31:0] playerData,
    output logic [31:0] enemyData1,
    output logic [31:0] enemyData2,
    output logic        frame_overrun
);

    localparam int CW = $clog2(FRAME_CYCLES);

    localparam logic [4:0] OFF_PLAYER = 5'h00;
    localparam logic [4:0] OFF_ENEMY1 = 5'h04;
    localparam logic [4:0] OFF_ENEMY2 = 5'h08;
    localparam logic [4:0] OFF_DONE   = 5'h0C;
    localparam logic [4:0] OFF_KEY    = 5'h10;
    localparam logic [4:0] OFF_OVR    = 5'h14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          tick;
    logic [31:0]   offset;
    logic          in_window;
    logic [4:0]    off;
    logic          wr_accept;
    logic          done_now;

    logic          wr_q;
    logic [4:0]    wr_off_q;
    logic [31:0]   wr_data_q;
    logic          done_q;

    logic [31:0]   player_sh;
    logic [31:0]   enemy1_sh;
    logic [31:0]   enemy2_sh;
    logic [8:0]    key_latch;
    logic [8:0]    key_reg;
    logic [7:0]    overrun_cnt;
    logic          pending_tick;

    assign tick      = (frame_cnt == CW'(FRAME_CYCLES - 1));
    assign offset    = cpu_addr - IO_BASE;
    assign in_window = (offset[31:5] == 27'd0);
    assign off       = offset[4:0];

    // Core writes pass through one register stage, so DONE reaches the FSM a cycle later.
    assign wr_accept = (state == RUN) && !done_q && cpu_we && in_window;
    assign done_now  = wr_accept && (off == OFF_DONE);
    assign done_q    = wr_q && (wr_off_q == OFF_DONE);

    always_comb begin
        cpu_rdata = 32'd0;
        if (in_window) begin
            case (off)
                OFF_PLAYER: cpu_rdata = player_sh;
                OFF_ENEMY1: cpu_rdata = enemy1_sh;
                OFF_ENEMY2: cpu_rdata = enemy2_sh;
                OFF_KEY:    cpu_rdata = {23'd0, key_reg};
                OFF_OVR:    cpu_rdata = {24'd0, overrun_cnt};
                default:    cpu_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cpu_stall     <= 1'b1;
            frame_cnt     <= '0;
            wr_q          <= 1'b0;
            wr_off_q      <= 5'd0;
            wr_data_q     <= 32'd0;
            player_sh     <= 32'd0;
            enemy1_sh     <= 32'd0;
            enemy2_sh     <= 32'd0;
            playerData    <= 32'd0;
            enemyData1    <= 32'd0;
            enemyData2    <= 32'd0;
            key_latch     <= 9'd0;
            key_reg       <= 9'd0;
            overrun_cnt   <= 8'd0;
            pending_tick  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_cnt     <= tick ? '0 : frame_cnt + CW'(1);
            frame_overrun <= 1'b0;

            wr_q      <= wr_accept;
            wr_off_q  <= off;
            wr_data_q <= cpu_wdata;

            if (wr_q) begin
                case (wr_off_q)
                    OFF_PLAYER: player_sh <= wr_data_q;
                    OFF_ENEMY1: enemy1_sh <= wr_data_q;
                    OFF_ENEMY2: enemy2_sh <= wr_data_q;
                    default:    ;
                endcase
            end

            if (ps2_valid) begin
                key_latch <= {1'b1, ps2_code};
            end

            case (state)
                IDLE: begin
                    if (tick || pending_tick) begin
                        state        <= RUN;
                        cpu_stall    <= 1'b0;
                        key_reg      <= ps2_valid ? {1'b1, ps2_code} : key_latch;
                        key_latch    <= 9'd0;
                        pending_tick <= 1'b0;
                    end
                end
                RUN: begin
                    if (done_q) begin
                        state     <= COMMIT;
                        cpu_stall <= 1'b1;
                        if (tick) begin
                            pending_tick <= 1'b1;
                        end
                    end else if (tick) begin
                        // A DONE arriving on the tick edge still finishes this frame.
                        if (done_now) begin
                            pending_tick <= 1'b1;
                        end else begin
                            frame_overrun <= 1'b1;
                            if (overrun_cnt != 8'hFF) begin
                                overrun_cnt <= overrun_cnt + 8'd1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    playerData <= player_sh;
                    enemyData1 <= enemy1_sh;
                    enemyData2 <= enemy2_sh;
                    state      <= IDLE;
                    if (tick) begin
                        pending_tick <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_stall <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_frame_controller.sv
// Directed bench for game_frame_controller with a 16-cycle frame; edge numbers
// count rising edges since the most recent reset release.
module tb_game_frame_controller;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ps2_valid;
    logic [7:0]  ps2_code;
    logic        cpu_stall;
    logic [31:0] playerData;
    logic [31:0] enemyData1;
    logic [31:0] enemyData2;
    logic        frame_overrun;

    int checks   = 0;
    int failures = 0;
    int now      = 0;

    game_frame_controller #(
        .FRAME_CYCLES(16),
        .IO_BASE     (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .ps2_valid    (ps2_valid),
        .ps2_code     (ps2_code),
        .cpu_stall    (cpu_stall),
        .playerData   (playerData),
        .enemyData1   (enemyData1),
        .enemyData2   (enemyData2),
        .frame_overrun(frame_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) now <= 0;
        else       now <= now + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
        @(negedge clk);
        cpu_we    = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        cpu_addr = addr;
        #1;
        checkOutput(tag, cpu_rdata, expected);
    endtask

    task automatic goToEdge(input int k);
        while (now < k) @(negedge clk);
    endtask

    initial begin
        $display("[TB] game_frame_controller directed test");
        reset = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        ps2_valid = 1'b0; ps2_code = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd1);
        checkOutput("rst_player", playerData, 32'd0);
        checkOutput("rst_enemy1", enemyData1, 32'd0);
        checkOutput("rst_enemy2", enemyData2, 32'd0);
        checkOutput("rst_overrun", 32'(frame_overrun), 32'd0);
        readCheck("rst_key", 32'h110, 32'd0);
        reset = 1'b0;

        // Two keys while idle, plus a write that must be ignored outside RUN
        goToEdge(2);
        ps2_valid = 1'b1; ps2_code = 8'h1C;
        @(negedge clk);
        ps2_code = 8'h23;
        @(negedge clk);
        ps2_valid = 1'b0; ps2_code = 8'h00;
        goToEdge(5);
        applyStimulus(32'h100, 32'hDEAD_BEEF);
        goToEdge(8);
        readCheck("idle_write_ignored", 32'h100, 32'd0);
        goToEdge(15);
        checkOutput("stall_before_first_tick", 32'(cpu_stall), 32'd1);
        goToEdge(16);
        checkOutput("run_after_first_tick", 32'(cpu_stall), 32'd0);
        readCheck("key_snapshot_newest", 32'h110, 32'h0000_0123);

        // Shadow writes and DONE commit
        applyStimulus(32'h100, 32'h0000_00A5);
        applyStimulus(32'h104, 32'h0000_0011);
        applyStimulus(32'h108, 32'h0000_0022);
        readCheck("shadow_player", 32'h100, 32'h0000_00A5);
        readCheck("shadow_enemy1", 32'h104, 32'h0000_0011);
        readCheck("outside_window_high", 32'h120, 32'd0);
        readCheck("outside_window_low", 32'h0FC, 32'd0);
        applyStimulus(32'h10C, 32'd1);
        checkOutput("done_edge_stall", 32'(cpu_stall), 32'd0);
        checkOutput("done_edge_player", playerData, 32'd0);
        readCheck("shadow_enemy2", 32'h108, 32'h0000_0022);
        readCheck("done_reads_zero", 32'h10C, 32'd0);
        @(negedge clk);
        checkOutput("commit_stall", 32'(cpu_stall), 32'd1);
        checkOutput("commit_player_unchanged", playerData, 32'd0);
        @(negedge clk);
        checkOutput("committed_player", playerData, 32'h0000_00A5);
        checkOutput("committed_enemy1", enemyData1, 32'h0000_0011);
        checkOutput("committed_enemy2", enemyData2, 32'h0000_0022);
        checkOutput("idle_after_commit_stall", 32'(cpu_stall), 32'd1);
        goToEdge(31);
        checkOutput("idle_until_tick", 32'(cpu_stall), 32'd1);
        goToEdge(32);
        checkOutput("run_frame2", 32'(cpu_stall), 32'd0);
        readCheck("key_empty_frame2", 32'h110, 32'd0);

        // Two missed frames
        goToEdge(47);
        checkOutput("no_overrun_before_tick", 32'(frame_overrun), 32'd0);
        goToEdge(48);
        checkOutput("overrun_pulse1", 32'(frame_overrun), 32'd1);
        goToEdge(49);
        checkOutput("overrun_pulse1_end", 32'(frame_overrun), 32'd0);
        goToEdge(50);
        applyStimulus(32'h100, 32'h0000_005A);
        goToEdge(64);
        checkOutput("overrun_pulse2", 32'(frame_overrun), 32'd1);
        goToEdge(65);
        readCheck("ovr_count_two", 32'h114, 32'd2);
        checkOutput("overrun_keeps_player", playerData, 32'h0000_00A5);
        goToEdge(66);
        applyStimulus(32'h10C, 32'd0);
        goToEdge(68);
        checkOutput("late_commit_stall", 32'(cpu_stall), 32'd1);
        checkOutput("late_commit_player_old", playerData, 32'h0000_00A5);
        goToEdge(69);
        checkOutput("late_commit_player_new", playerData, 32'h0000_005A);

        // DONE on the tick edge, RO/unmapped writes ignored
        goToEdge(80);
        checkOutput("run_frame5", 32'(cpu_stall), 32'd0);
        goToEdge(82);
        applyStimulus(32'h104, 32'h0000_0077);
        goToEdge(85);
        ps2_valid = 1'b1; ps2_code = 8'h42;
        @(negedge clk);
        ps2_valid = 1'b0; ps2_code = 8'h00;
        goToEdge(87);
        applyStimulus(32'h110, 32'hFFFF_FFFF);
        applyStimulus(32'h118, 32'h1234_5678);
        goToEdge(90);
        readCheck("ro_key_write_ignored", 32'h110, 32'd0);
        readCheck("unmapped_reads_zero", 32'h118, 32'd0);
        readCheck("shadow_enemy1_new", 32'h104, 32'h0000_0077);
        goToEdge(95);
        applyStimulus(32'h10C, 32'd0);
        checkOutput("done_on_tick_no_overrun", 32'(frame_overrun), 32'd0);
        checkOutput("done_on_tick_still_run", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        checkOutput("tick_commit_stall", 32'(cpu_stall), 32'd1);
        checkOutput("tick_commit_enemy1_old", enemyData1, 32'h0000_0011);
        @(negedge clk);
        checkOutput("tick_commit_enemy1_new", enemyData1, 32'h0000_0077);
        checkOutput("tick_commit_player", playerData, 32'h0000_005A);
        checkOutput("tick_commit_idle_stall", 32'(cpu_stall), 32'd1);
        readCheck("key_before_resume", 32'h110, 32'd0);
        @(negedge clk);
        checkOutput("pending_tick_resume", 32'(cpu_stall), 32'd0);
        readCheck("fresh_key_snapshot", 32'h110, 32'h0000_0142);
        readCheck("ovr_unchanged", 32'h114, 32'd2);

        // Reset mid-frame discards shadows
        goToEdge(100);
        applyStimulus(32'h100, 32'h0000_00EE);
        @(negedge clk);
        readCheck("shadow_before_reset", 32'h100, 32'h0000_00EE);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset2_stall", 32'(cpu_stall), 32'd1);
        checkOutput("reset2_player", playerData, 32'd0);
        checkOutput("reset2_enemy1", enemyData1, 32'd0);
        checkOutput("reset2_enemy2", enemyData2, 32'd0);
        readCheck("reset2_shadow_player", 32'h100, 32'd0);
        readCheck("reset2_shadow_enemy1", 32'h104, 32'd0);
        readCheck("reset2_ovr", 32'h114, 32'd0);
        goToEdge(16);
        checkOutput("reset2_run", 32'(cpu_stall), 32'd0);
        checkOutput("reset2_player_still0", playerData, 32'd0);

        // Overrun counter saturation
        goToEdge(4081);
        readCheck("ovr_254", 32'h114, 32'd254);
        goToEdge(4097);
        readCheck("ovr_255", 32'h114, 32'd255);
        goToEdge(4176);
        checkOutput("overrun_pulse_saturated", 32'(frame_overrun), 32'd1);
        goToEdge(4177);
        readCheck("ovr_saturated", 32'h114, 32'd255);
        checkOutput("saturated_player_still0", playerData, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_frame_controller.md
Name: game_frame_controller

Overview:
- Frame-level sequencer between the game processor core and its I/O.
- Gates the core with a stall signal once per frame and snapshots the newest PS/2 keycode for the core to read.
- Collects the core's memory-mapped writes to shadow player/enemy registers, then commits them atomically to playerData/enemyData1/enemyData2 when the core signals frame done.
- Flags and counts frames the core fails to finish in time.

Parameters:
- FRAME_CYCLES, 1000: clock cycles per frame period; must be ≥ 4.
- IO_BASE, 32'h0000_0100: byte address of the I/O window, word-aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_we  in  1  core data-memory write strobe
- cpu_addr  in  32  core data address
- cpu_wdata  in  32  core write data
- cpu_rdata  out  32  read data for I/O window (combinational on cpu_addr); 0 outside window
- ps2_valid  in  1  one-cycle pulse, new keycode present
- ps2_code  in  8  keycode, valid with ps2_valid
- cpu_stall  out  1  1 = core must hold state
- playerData  out  32  committed player word
- enemyData1  out  32  committed enemy 1 word
- enemyData2  out  32  committed enemy 2 word
- frame_overrun  out  1  one-cycle pulse on missed frame

Behaviour:
Reset:
- State IDLE, cpu_stall=1, frame counter=0.
- All shadow/committed data, key_latch, key_reg, overrun_cnt, pending_tick = 0.
- frame_overrun=0.
- Reset mid-frame discards shadows with no commit.

I/O map (offset from IO_BASE):
- +0x00 player shadow (R/W)
- +0x04 enemy1 shadow (R/W)
- +0x08 enemy2 shadow (R/W)
- +0x0C DONE (write any value; reads 0)
- +0x10 KEY (RO) = {23'b0, valid, code}
- +0x14 OVR (RO) = {24'b0, overrun_cnt}
- Writes to RO offsets, or to unmapped offsets inside window +0x00..+0x1F, are ignored.
- Writes are accepted only in RUN with cpu_we=1.

Frame counter:
- Free-running 0..FRAME_CYCLES-1, wraps to 0.
- tick=1 in the cycle the count equals FRAME_CYCLES-1.

PS/2 capture:
- On ps2_valid, key_latch <= {1, ps2_code}; the newest code overwrites.

FSM:
- IDLE (stall=1):
  - On tick or pending_tick: -> RUN.
  - Same edge: key_reg <= key_latch, key_latch cleared, pending_tick cleared.
  - If ps2_valid in that same cycle: key_reg <= {1, ps2_code}, latch cleared.
- RUN (stall=0):
  - Write to DONE -> COMMIT.
  - tick without DONE -> stay RUN, frame_overrun=1 next cycle, overrun_cnt += 1 saturating at 255, no commit, key_reg unchanged.
  - DONE and tick same cycle -> COMMIT and set pending_tick; no overrun.
- COMMIT (stall=1, one cycle):
  - At its closing edge, outputs <= shadows, then -> IDLE.
  - tick during COMMIT sets pending_tick.

Latency:
- DONE sampled at edge N; COMMIT during cycle N+1; outputs change at edge N+2.
- With pending_tick, RUN resumes at edge N+3.
- Shadow write sampled at edge N is readable from cycle N+1.
- Shadows persist across frames; they are not cleared on commit.

Test Plan (FRAME_CYCLES=16, IO_BASE=0x100):
1. Reset held 3 cycles, then released -> stall=1, all data outputs 0, cpu_rdata at 0x110 = 0; first RUN entered after count 15.
2. ps2 pulses 0x1C then 0x23 in IDLE; frame start -> read 0x110 = 0x123; next frame with no key -> read 0x110 = 0x000.
3. In RUN write 0x100=0xA5, 0x104=0x11, 0x108=0x22, then DONE -> outputs 0xA5/0x11/0x22 exactly 2 edges after DONE edge; stall high 1 cycle; outputs unchanged before that edge.
4. No DONE for 2 ticks -> frame_overrun pulses twice; 0x114 reads 2; outputs keep prior values; DONE afterwards commits normally.
5. DONE written in tick cycle -> commit occurs, no overrun; RUN re-entered at edge N+3 with fresh key snapshot.
6. Reset asserted in RUN after shadow writes -> outputs stay 0, shadows 0, stall=1 next cycle; 260 forced overruns -> OVR saturates at 255.
